// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-wide data memory.
// Optional: define LSU_BOUNDS_CHECK_EN to reject accesses beyond MEM_WORDS.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_err;
  logic        w_oob;
  logic        w_beyond;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_accept = req_valid && (r_state == S_IDLE);

  assign w_beyond = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

`ifdef LSU_BOUNDS_CHECK_EN
  assign w_oob = w_beyond;
`else
  // Out-of-range words go to memory untouched and alias there.
  assign w_oob = w_beyond & 1'b0;
`endif

  // Classify the incoming request as legal or rejected.
  always_comb begin
    w_err = w_oob;
    case (req_funct3)
      3'b000: w_err = w_err;
      3'b001: w_err = w_err | req_addr[0];
      3'b010: w_err = w_err | (req_addr[1:0] != 2'b00);
      3'b100: w_err = w_err | req_we;
      3'b101: w_err = w_err | req_we | req_addr[0];
      default: w_err = 1'b1;
    endcase
  end

  // Select the addressed lane and extend it for loads.
  always_comb begin
    w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_sign = ~r_funct3[2];
    case (r_funct3[1:0])
      2'b00:   w_load = {{24{w_sign & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{w_sign & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Overlay the store lane onto the word read back for a sub-word store.
  always_comb begin
    w_merged = r_merge;
    if (r_funct3[0]) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end else begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end
  end

  // Access sequencer: accept, touch memory, then a one-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_err    <= w_err;
            r_rdata  <= '0;
            if (w_err)              r_state <= S_RESP;
            else if (!req_we)       r_state <= S_READ;
            else if (req_funct3[1]) r_state <= S_WRITE;
            else                    r_state <= S_RMW_RD;
          end
        end
        S_READ: begin
          r_rdata <= r_we ? '0 : w_load;
          r_state <= S_RESP;
        end
        S_WRITE: r_state <= S_RESP;
        S_RMW_RD: begin
          r_merge <= mem_rdata;
          r_state <= S_RMW_WR;
        end
        S_RMW_WR: r_state <= S_RESP;
        S_RESP: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign mem_read  = (r_state == S_READ) || (r_state == S_RMW_RD);
  assign mem_write = (r_state == S_WRITE) || (r_state == S_RMW_WR);
  assign mem_addr  = (mem_read || mem_write) ? {r_addr[31:2], 2'b00} : '0;
  assign mem_wdata = (r_state == S_WRITE)  ? r_wdata  :
                     (r_state == S_RMW_WR) ? w_merged : '0;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rdata;

endmodule
